// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the pipeline MEM stage has fixed priority, a DMA/loader port gets
// a forced slot after STARVE_MAX contested losses, and read data is routed back to its issuer.
module dm_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    output logic              pipe_rvalid,
    output logic [DATA_W-1:0] pipe_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [1:0] rd_owner;   // bit0 = pipeline, bit1 = DMA
    logic       dma_win;
    logic       pipe_win;

    // DMA wins when alone, or when it has lost STARVE_MAX contested cycles in a row.
    assign dma_win  = !reset && dma_req && (!pipe_req || (cnt_q == STARVE_LIM));
    assign pipe_win = !reset && pipe_req && !dma_win;

    assign dma_gnt    = dma_win;
    assign pipe_stall = pipe_req && dma_win;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (dma_win) begin
            mem_en   = 1'b1;
            mem_we   = dma_we;
            mem_addr = dma_addr;
            mem_din  = dma_wdata;
        end else if (pipe_win) begin
            mem_en   = 1'b1;
            mem_we   = pipe_we;
            mem_addr = pipe_addr;
            mem_din  = pipe_wdata;
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            rd_owner <= '0;
        end else begin
            rd_owner <= {dma_win && !dma_we, pipe_win && !pipe_we};
            if (dma_win || !dma_req) begin
                cnt_q <= '0;
            end else if (pipe_win && (cnt_q != STARVE_LIM)) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // Reset masks everything visible, including a read return already in flight.
    assign pipe_rvalid = rd_owner[0] && !reset;
    assign dma_rvalid  = rd_owner[1] && !reset;
    assign pipe_rdata  = pipe_rvalid ? mem_dout : '0;
    assign dma_rdata   = dma_rvalid ? mem_dout : '0;
    assign starve_cnt  = reset ? 4'd0 : cnt_q;

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Arbitrates the single-port 16-bit data memory between two requesters: the pipeline MEM stage and a DMA/loader port (program/data preload, debug readback).
- Sits between the MEM stage and the data-memory block RAM. Drives the RAM's en/we/addr/din and routes the 1-cycle-latency read data back to whichever requester issued the read.
- The pipeline has fixed priority. An anti-starvation counter forces a DMA slot and asserts a pipeline stall.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
STARVE_MAX, 4, consecutive lost cycles after which a waiting DMA request wins (1..15)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
pipe_req  in  1  pipeline memory access request (mem_en_ex)
pipe_we  in  1  pipeline write (1) / read (0)
pipe_addr  in  ADDR_W  pipeline address (ALU result)
pipe_wdata  in  DATA_W  pipeline store data
pipe_stall  out  1  pipeline access not accepted this cycle; hold MEM stage
pipe_rvalid  out  1  pipe_rdata valid (cycle after accepted read)
pipe_rdata  out  DATA_W  read data to pipeline
dma_req  in  1  DMA access request; held until dma_gnt
dma_we  in  1  DMA write/read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access accepted this cycle
dma_rvalid  out  1  dma_rdata valid (cycle after granted read)
dma_rdata  out  DATA_W  read data to DMA
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_din  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM read data, valid 1 cycle after en & !we
starve_cnt  out  4  current starvation count (status/debug)

Behaviour:
- Grant decision is combinational in the current cycle. The RAM samples the granted request on the next rising edge.
- Grant rules:
  - Neither requester: mem_en=0, no grant.
  - Only pipe_req: pipeline granted.
  - Only dma_req: dma_gnt=1.
  - Both, starve_cnt < STARVE_MAX: pipeline granted. dma_gnt=0.
  - Both, starve_cnt == STARVE_MAX: dma_gnt=1, pipe_stall=1.
- pipe_stall = pipe_req & dma_gnt. It is never asserted without pipe_req.
- Mux: mem_en=1 when either requester is granted. mem_we/addr/din come from the granted requester. When idle: mem_we=0, addr/din=0.
- Starvation counter (register):
  - On reset: 0.
  - dma_req & pipe granted: +1, saturating at STARVE_MAX.
  - dma_gnt: cleared to 0.
  - dma_req=0: cleared to 0.
- Read return tracking: registered rd_owner[1:0] (bit0 = pipe, bit1 = dma).
  - Set at the edge where a granted read (mem_en & !mem_we) is issued. Otherwise cleared.
  - pipe_rvalid = rd_owner[0]; dma_rvalid = rd_owner[1]. At most one is set in any cycle.
- Read data routing:
  - pipe_rdata = mem_dout when pipe_rvalid, else 0.
  - dma_rdata = mem_dout when dma_rvalid, else 0.
- Writes produce no rvalid. Back-to-back reads from alternating owners return in issue order, one per cycle.
- Reset (sampled high at an edge): starve_cnt=0, rd_owner=0.
- While reset is high, mem_en, mem_we, dma_gnt and pipe_stall are forced to 0, overriding requests. All outputs read 0.
- A read issued in the cycle reset is asserted does not produce rvalid afterwards.
- Read-after-write to the same address in the next cycle returns the new data; this relies on RAM read-first/write-first semantics, not the arbiter.
- Latency: grant 0 cycles; read data 1 cycle after grant.

Test Plan:
- Reset held 2 cycles with pipe_req=dma_req=1 -> mem_en=0, dma_gnt=0, pipe_stall=0, starve_cnt=0, no rvalid after release.
- DMA write addr 0x0010 data 0xBEEF alone; then pipe read 0x0010 -> dma_gnt=1 cycle 0; pipe_rvalid=1 next cycle with pipe_rdata=0xBEEF, dma_rvalid=0.
- Both request continuously, STARVE_MAX=4 -> pipe granted 4 cycles (starve_cnt 1,2,3,4), cycle 5 dma_gnt=1 and pipe_stall=1, starve_cnt returns to 0, pattern repeats.
- Alternating reads: pipe read 0x0001 then DMA read 0x0002 in consecutive cycles (RAM preloaded 0x1111/0x2222) -> pipe_rvalid with 0x1111, then dma_rvalid with 0x2222; never both high.
- dma_req drops at starve_cnt=3 then reasserts -> counter cleared to 0, DMA waits a full 4 more contested cycles.
- Reset asserted in the cycle after a granted pipe read -> pipe_rvalid=0 during reset, starve_cnt=0, mem_en=0.
